// File: rtl/pattern_gen_scheduler_pkg.sv
// Shared types for the pattern generator and the scheduler that arbitrates access to it.
package pattern_gen_scheduler_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_A    = 2'd1,
    SEQ_B    = 2'd2,
    SEQ_C    = 2'd3
  } states_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4
  } sched_state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_TMO  = 2'd1,
    ERR_ACNT = 2'd2,
    ERR_SEQ  = 2'd3
  } err_code_t;

  // A-phase count saturates at 3 so any excess is still distinguishable from 2.
  function automatic logic [1:0] sat_inc_acnt(logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

endpackage

// File: rtl/pattern_gen_scheduler_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick
  import pattern_gen_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  int               cand;
  logic [PTR_W-1:0] cand_idx;

  always_comb begin
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_idx = cand[PTR_W-1:0];
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/pattern_gen_scheduler.sv
// Shares one A-B-B-B-A-C pattern generator between N_REQ requesters and
// validates each job's phase sequence before reporting done or error.
module pattern_gen_scheduler
  import pattern_gen_scheduler_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_grant,
  output logic [N_REQ-1:0] o_done,
  output logic             o_err,
  output logic [1:0]       o_err_code,
  output logic             o_busy,
  output logic             o_gen_req,
  input  logic [1:0]       i_gen_seq,
  input  logic             i_gen_running
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  sched_state_t     state, next_state;
  states_t          seq, prev_seq;
  logic [PTR_W-1:0] ptr, owner;
  logic [1:0]       a_cnt, a_cnt_next;
  logic [WD_W-1:0]  wd_cnt;

  logic [N_REQ-1:0] pick_grant;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;

  logic      take, release_job, done_fire, err_fire, wd_expired;
  err_code_t err_next;

  assign seq        = states_t'(i_gen_seq);
  assign wd_expired = (wd_cnt == WD_LAST);

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req   (i_req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    next_state  = state;
    a_cnt_next  = a_cnt;
    take        = 1'b0;
    release_job = 1'b0;
    done_fire   = 1'b0;
    err_fire    = 1'b0;
    err_next    = ERR_NONE;
    case (state)
      S_IDLE: begin
        if (pick_any && seq == SEQ_IDLE) begin
          take       = 1'b1;
          a_cnt_next = 2'd0;
          next_state = S_LAUNCH;
        end
      end
      S_LAUNCH: next_state = S_WAIT;
      S_WAIT: begin
        if (seq == SEQ_A) begin
          a_cnt_next = 2'd1;
          next_state = S_RUN;
        end else if (seq == SEQ_B || seq == SEQ_C) begin
          err_fire   = 1'b1;
          err_next   = ERR_SEQ;
          next_state = S_DRAIN;
        end else if (wd_expired) begin
          err_fire    = 1'b1;
          err_next    = ERR_TMO;
          release_job = 1'b1;
          next_state  = S_IDLE;
        end
      end
      S_RUN: begin
        if (seq == SEQ_A && prev_seq != SEQ_A) begin
          a_cnt_next = sat_inc_acnt(a_cnt);
        end
        // Only the A count accumulated before C matters; C itself never counts.
        if (seq == SEQ_C) begin
          if (a_cnt == 2'd2) begin
            done_fire = 1'b1;
          end else begin
            err_fire = 1'b1;
            err_next = ERR_ACNT;
          end
          next_state = S_DRAIN;
        end else if (seq == SEQ_IDLE) begin
          err_fire   = 1'b1;
          err_next   = ERR_SEQ;
          next_state = S_DRAIN;
        end else if (wd_expired) begin
          err_fire    = 1'b1;
          err_next    = ERR_TMO;
          release_job = 1'b1;
          next_state  = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (seq == SEQ_IDLE && !i_gen_running) begin
          release_job = 1'b1;
          next_state  = S_IDLE;
        end else if (wd_expired) begin
          err_fire    = 1'b1;
          err_next    = ERR_TMO;
          release_job = 1'b1;
          next_state  = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= S_IDLE;
      prev_seq   <= SEQ_IDLE;
      ptr        <= '0;
      owner      <= '0;
      a_cnt      <= 2'd0;
      wd_cnt     <= '0;
      o_grant    <= '0;
      o_done     <= '0;
      o_err      <= 1'b0;
      o_err_code <= ERR_NONE;
      o_busy     <= 1'b0;
      o_gen_req  <= 1'b0;
    end else begin
      state     <= next_state;
      prev_seq  <= seq;
      a_cnt     <= a_cnt_next;
      o_gen_req <= (next_state == S_LAUNCH);
      o_busy    <= (next_state != S_IDLE);
      o_done    <= done_fire ? o_grant : '0;
      o_err     <= err_fire;
      if (err_fire) begin
        o_err_code <= err_next;
      end
      // Watchdog measures time spent in the current state only.
      if (next_state != state) begin
        wd_cnt <= '0;
      end else if (!wd_expired) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (take) begin
        o_grant <= pick_grant;
        owner   <= pick_idx;
      end else if (release_job) begin
        o_grant <= '0;
        ptr     <= (owner == PTR_LAST) ? '0 : owner + PTR_W'(1);
      end
    end
  end

endmodule
